// File: rtl/atm_pkg.sv
// Shared constants for the ATM statement reader: FSM encodings,
// log entry layout and parameter defaults.
package atm_pkg;

   localparam int DEPTH_DEF    = 16;
   localparam int AMT_W_DEF    = 16;
   localparam int STMT_LEN_DEF = 5;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SEND  = 2'd1;
   localparam logic [1:0] S_TRAIL = 2'd2;

   // Entry layout: {is_dep, amount, balance}, balance in the low bits
   function automatic int ent_w(input int aw);
      return 1 + 2 * aw;
   endfunction

endpackage

// File: rtl/stmt_log_ram.sv
// Transaction log storage: DEPTH x W register file,
// one synchronous write port and one asynchronous read port.
module stmt_log_ram #(
   parameter int DEPTH = 16,
   parameter int W     = 33
) (
   input  logic                     clk,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] waddr_i,
   input  logic [W-1:0]             wdata_i,
   input  logic [$clog2(DEPTH)-1:0] raddr_i,
   output logic [W-1:0]             rdata_o
);

   logic [W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mini_stmt_reader.sv
// Mini statement reader: circular transaction log streamed newest first.
// Define STMT_CHECKSUM_EN to append an XOR checksum trailer beat.
module mini_stmt_reader
   import atm_pkg::*;
#(
   parameter int DEPTH    = DEPTH_DEF,
   parameter int AMT_W    = AMT_W_DEF,
   parameter int STMT_LEN = STMT_LEN_DEF
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       log_valid,
   input  logic                       log_is_dep,
   input  logic [AMT_W-1:0]           log_amount,
   input  logic [AMT_W-1:0]           log_balance,
   output logic                       log_overflow,
   output logic [$clog2(DEPTH+1)-1:0] entry_count,
   input  logic                       stmt_req,
   output logic                       stmt_busy,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic                       out_is_dep,
   output logic [AMT_W-1:0]           out_amount,
   output logic [AMT_W-1:0]           out_balance,
   output logic                       out_none,
   output logic                       out_trailer,
   output logic                       out_last
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam int EW = ent_w(AMT_W);
`ifdef STMT_CHECKSUM_EN
   localparam logic CS_EN = 1'b1;
`else
   localparam logic CS_EN = 1'b0;
`endif

   logic [1:0]       state_q, state_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, raddr;
   logic [CW-1:0]    cnt_q, cnt_d, rem_q, rem_d;
   logic [CW-1:0]    wcnt_q, wcnt_d, lim_q, lim_d, n_snap;
   logic             vld_q, vld_d, dep_q, dep_d, none_q, none_d;
   logic             trl_q, trl_d, last_q, last_d, ovf_q, ovf_d;
   logic [AMT_W-1:0] amt_q, amt_d, bal_q, bal_d, xor_q, xor_d;
   logic [EW-1:0]    rdata;
   logic             accept, xfer, go_idle;

   stmt_log_ram #(.DEPTH(DEPTH), .W(EW)) u_ram (
      .clk     (clk),
      .we_i    (accept),
      .waddr_i (wr_ptr_q),
      .wdata_i ({log_is_dep, log_amount, log_balance}),
      .raddr_i (raddr),
      .rdata_o (rdata)
   );

   assign n_snap = (cnt_q > CW'(STMT_LEN)) ? CW'(STMT_LEN) : cnt_q;
   // Writes past lim would overwrite snapshot entries not yet read
   assign accept = log_valid && (state_q == S_IDLE || wcnt_q < lim_q);
   assign raddr  = (state_q == S_IDLE) ? wr_ptr_q - PW'(1) : rd_ptr_q;
   assign xfer   = vld_q && out_ready;

   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      rem_d    = rem_q;
      wcnt_d   = wcnt_q;
      lim_d    = lim_q;
      vld_d    = vld_q;
      dep_d    = dep_q;
      amt_d    = amt_q;
      bal_d    = bal_q;
      none_d   = none_q;
      trl_d    = trl_q;
      last_d   = last_q;
      xor_d    = xor_q;
      go_idle  = 1'b0;
      ovf_d    = log_valid && !accept;
      if (accept) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
         if (cnt_q != CW'(DEPTH)) cnt_d = cnt_q + CW'(1);
         if (state_q != S_IDLE) wcnt_d = wcnt_q + CW'(1);
      end
      unique case (state_q)
         S_IDLE: begin
            if (stmt_req) begin
               state_d = S_SEND;
               vld_d   = 1'b1;
               trl_d   = 1'b0;
               xor_d   = '0;
               lim_d   = CW'(DEPTH) - n_snap;
               wcnt_d  = CW'(log_valid);
               if (n_snap == '0) begin
                  none_d = 1'b1;
                  dep_d  = 1'b0;
                  amt_d  = '0;
                  bal_d  = '0;
                  rem_d  = '0;
                  last_d = !CS_EN;
               end else begin
                  none_d   = 1'b0;
                  {dep_d, amt_d, bal_d} = rdata;
                  rd_ptr_d = wr_ptr_q - PW'(2);
                  rem_d    = n_snap - CW'(1);
                  last_d   = (n_snap == CW'(1)) && !CS_EN;
               end
            end
         end
         S_SEND: begin
            if (xfer) begin
               xor_d = xor_q ^ amt_q;
               if (rem_q == '0) begin
`ifdef STMT_CHECKSUM_EN
                  state_d = S_TRAIL;
                  trl_d   = 1'b1;
                  last_d  = 1'b1;
                  none_d  = 1'b0;
                  dep_d   = 1'b0;
                  bal_d   = '0;
                  amt_d   = xor_q ^ amt_q;
`else
                  go_idle = 1'b1;
`endif
               end else begin
                  {dep_d, amt_d, bal_d} = rdata;
                  none_d   = 1'b0;
                  rd_ptr_d = rd_ptr_q - PW'(1);
                  rem_d    = rem_q - CW'(1);
                  last_d   = (rem_q == CW'(1)) && !CS_EN;
               end
            end
         end
`ifdef STMT_CHECKSUM_EN
         S_TRAIL: begin
            if (xfer) go_idle = 1'b1;
         end
`endif
         default: state_d = S_IDLE;
      endcase
      if (go_idle) begin
         state_d = S_IDLE;
         vld_d   = 1'b0;
         dep_d   = 1'b0;
         amt_d   = '0;
         bal_d   = '0;
         none_d  = 1'b0;
         trl_d   = 1'b0;
         last_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         rem_q    <= '0;
         wcnt_q   <= '0;
         lim_q    <= '0;
         vld_q    <= 1'b0;
         dep_q    <= 1'b0;
         amt_q    <= '0;
         bal_q    <= '0;
         none_q   <= 1'b0;
         trl_q    <= 1'b0;
         last_q   <= 1'b0;
         xor_q    <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         rem_q    <= rem_d;
         wcnt_q   <= wcnt_d;
         lim_q    <= lim_d;
         vld_q    <= vld_d;
         dep_q    <= dep_d;
         amt_q    <= amt_d;
         bal_q    <= bal_d;
         none_q   <= none_d;
         trl_q    <= trl_d;
         last_q   <= last_d;
         xor_q    <= xor_d;
         ovf_q    <= ovf_d;
      end
   end

   assign log_overflow = ovf_q;
   assign entry_count  = cnt_q;
   assign stmt_busy    = (state_q != S_IDLE);
   assign out_valid    = vld_q;
   assign out_is_dep   = dep_q;
   assign out_amount   = amt_q;
   assign out_balance  = bal_q;
   assign out_none     = none_q;
   assign out_trailer  = trl_q;
   assign out_last     = last_q;

endmodule

// File: tb/tb_mini_stmt_reader.sv
// Scoreboard bench for mini_stmt_reader: a history-list model predicts
// each statement at request time; a negedge monitor checks every beat.
module tb_mini_stmt_reader;

   localparam int DEPTH    = 16;
   localparam int AMT_W    = 16;
   localparam int STMT_LEN = 5;
`ifdef STMT_CHECKSUM_EN
   localparam bit CS = 1'b1;
`else
   localparam bit CS = 1'b0;
`endif

   typedef struct {
      bit dep;
      int amt;
      int bal;
   } ent_t;

   typedef struct {
      bit dep;
      int amt;
      int bal;
      bit none;
      bit trl;
      bit last;
   } beat_t;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic             log_valid = 1'b0;
   logic             log_is_dep = 1'b0;
   logic [AMT_W-1:0] log_amount = '0;
   logic [AMT_W-1:0] log_balance = '0;
   logic             log_overflow;
   logic [4:0]       entry_count;
   logic             stmt_req = 1'b0;
   logic             stmt_busy;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic             out_is_dep;
   logic [AMT_W-1:0] out_amount;
   logic [AMT_W-1:0] out_balance;
   logic             out_none;
   logic             out_trailer;
   logic             out_last;

   mini_stmt_reader #(
      .DEPTH(DEPTH), .AMT_W(AMT_W), .STMT_LEN(STMT_LEN)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .log_valid    (log_valid),
      .log_is_dep   (log_is_dep),
      .log_amount   (log_amount),
      .log_balance  (log_balance),
      .log_overflow (log_overflow),
      .entry_count  (entry_count),
      .stmt_req     (stmt_req),
      .stmt_busy    (stmt_busy),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_is_dep   (out_is_dep),
      .out_amount   (out_amount),
      .out_balance  (out_balance),
      .out_none     (out_none),
      .out_trailer  (out_trailer),
      .out_last     (out_last)
   );

   always #5 clk = ~clk;

   int    total = 0;
   int    bad = 0;
   ent_t  hist[$];
   beat_t sb[$];
   bit    m_busy = 0;
   int    m_w = 0;
   int    m_lim = 0;
   int    exp_ovf = 0;
   int    ovf_seen = 0;

   task automatic chk(string nm, longint unsigned act, longint unsigned exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [35:0] pack(beat_t b);
      return {b.dep, b.amt[15:0], b.bal[15:0], b.none, b.trl, b.last};
   endfunction

   function automatic int model_count();
      return (hist.size() > DEPTH) ? DEPTH : hist.size();
   endfunction

   // Statement = newest min(count, STMT_LEN) history entries, newest first
   task automatic snap();
      int    n;
      int    x;
      beat_t b;
      ent_t  e;
      n = model_count();
      if (n > STMT_LEN) n = STMT_LEN;
      x = 0;
      if (n == 0) begin
         b = '{0, 0, 0, 1, 0, !CS};
         sb.push_back(b);
      end
      for (int i = 0; i < n; i++) begin
         e = hist[hist.size() - 1 - i];
         x = x ^ e.amt;
         b = '{e.dep, e.amt, e.bal, 0, 0, (i == n - 1) && !CS};
         sb.push_back(b);
      end
      if (CS) begin
         b = '{0, x, 0, 0, 1, 1};
         sb.push_back(b);
      end
      m_busy = 1;
      m_w    = 0;
      m_lim  = DEPTH - n;
   endtask

   task automatic cyc(bit lv, bit dep, int amt, int bal, bit req);
      bit   drop;
      bit   do_req;
      ent_t e;
      drop   = 0;
      do_req = req && !m_busy;
      log_valid   = lv;
      log_is_dep  = dep;
      log_amount  = amt[15:0];
      log_balance = bal[15:0];
      stmt_req    = req;
      if (do_req) snap();
      if (lv) begin
         if (m_busy && m_w >= m_lim) begin
            drop = 1;
            exp_ovf++;
         end else begin
            e = '{dep, amt & 16'hffff, bal & 16'hffff};
            hist.push_back(e);
            if (m_busy) m_w++;
         end
      end
      @(posedge clk);
      #1;
      log_valid = 0;
      stmt_req  = 0;
      if (lv) chk("ovf_pulse", log_overflow, drop);
      chk("entry_count", entry_count, model_count());
      if (do_req) begin
         chk("req_valid", out_valid, 1);
         chk("req_busy", stmt_busy, 1);
      end
   endtask

   task automatic rnd_log();
      cyc(1, 1'($urandom_range(0, 1)), $urandom_range(0, 65535),
          $urandom_range(0, 65535), 0);
   endtask

   task automatic drain(bit rnd);
      int k;
      k = 0;
      while (k < 400 && (stmt_busy || sb.size() != 0)) begin
         out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         @(posedge clk);
         #1;
         k++;
      end
      out_ready = 0;
      chk("drain_left", sb.size(), 0);
      chk("drain_busy", stmt_busy, 0);
      chk("drain_valid", out_valid, 0);
      m_busy = 0;
   endtask

   logic [35:0] obs;
   logic [35:0] held;
   bit          stall_prev = 0;
   bit          need_valid = 0;
   beat_t       eb;

   always @(negedge clk) begin
      if (!reset_n) begin
         stall_prev = 0;
         need_valid = 0;
      end else begin
         obs = {out_is_dep, out_amount, out_balance,
                out_none, out_trailer, out_last};
         if (log_overflow) ovf_seen++;
         if (stall_prev) chk("stall_stable", obs, held);
         if (need_valid) chk("no_bubble", out_valid, 1);
         stall_prev = 0;
         need_valid = 0;
         if (out_valid && !out_ready) begin
            stall_prev = 1;
            held = obs;
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_beat got=%0h want=none", obs);
            end else begin
               eb = sb.pop_front();
               chk("beat", obs, pack(eb));
               need_valid = !out_last;
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=running want=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #3;
      chk("rst_valid", out_valid, 0);
      chk("rst_busy", stmt_busy, 0);
      chk("rst_count", entry_count, 0);
      chk("rst_ovf", log_overflow, 0);
      reset_n = 1;
      @(posedge clk);
      #1;

      // empty log statement
      cyc(0, 0, 0, 0, 1);
      drain(0);

      // three transactions, back-to-back beats
      cyc(1, 1, 100, 100, 0);
      cyc(1, 1, 200, 300, 0);
      cyc(1, 0, 50, 250, 0);
      cyc(0, 0, 0, 0, 1);
      drain(0);

      // wrap past DEPTH
      for (int i = 1; i <= 20; i++) cyc(1, 1, i, 1000 + i, 0);
      chk("count_sat", entry_count, DEPTH);
      cyc(0, 0, 0, 0, 1);
      drain(0);

      // mid-statement stall, then request coinciding with a write
      cyc(0, 0, 0, 0, 1);
      out_ready = 1;
      @(posedge clk);
      #1;
      out_ready = 0;
      repeat (3) @(posedge clk);
      #1;
      drain(0);
      cyc(1, 0, 7, 777, 1);
      drain(0);
      cyc(0, 0, 0, 0, 1);
      drain(0);

      // overflow guard on a full log, plus ignored re-request
      cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 1);
      for (int i = 0; i < 12; i++) cyc(1, 0, 500 + i, 9000 + i, 0);
      @(posedge clk);
      #1;
      chk("ovf_single", log_overflow, 0);
      chk("ovf_count", entry_count, DEPTH);
      drain(1);

      // randomized traffic with writes during stalled statements
      for (int it = 0; it < 30; it++) begin
         repeat ($urandom_range(0, 6)) rnd_log();
         cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             $urandom_range(0, 65535), $urandom_range(0, 65535), 1);
         repeat ($urandom_range(0, 13)) rnd_log();
         drain(1);
      end

      // async reset mid-statement
      cyc(0, 0, 0, 0, 1);
      @(posedge clk);
      #3;
      reset_n = 0;
      #1;
      chk("arst_valid", out_valid, 0);
      chk("arst_busy", stmt_busy, 0);
      chk("arst_count", entry_count, 0);
      sb.delete();
      hist.delete();
      m_busy = 0;
      @(posedge clk);
      #1;
      reset_n = 1;
      @(posedge clk);
      #1;

      cyc(1, 1, 100, 100, 0);
      cyc(1, 1, 200, 300, 0);
      cyc(1, 0, 50, 250, 0);
      cyc(0, 0, 0, 0, 1);
      drain(0);

      chk("ovf_total", ovf_seen, exp_ovf);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
